// File: rtl/hilo_mul_unit.sv
// HI/LO register unit for a single-cycle MIPS datapath.
//
// Registers the multiply operands and drives them to the external combinational
// 32x32 multipliers. The operands are held stable for MUL_CYCLES cycles, and then
// the signed or unsigned 64-bit product is captured into HI/LO. The unit also
// services MTHI/MTLO. While a multiply is in flight it raises busy so the CPU stalls.
//
// Ports:
//   clk, rst_n            clock (rising edge); asynchronous active-low reset
//   req, op[2:0]          request strobe and opcode
//                         (000 NONE, 001 MULT, 010 MULTU, 011 MTHI, 100 MTLO)
//   rs_data, rt_data      source operands
//   mul_a, mul_b          registered operands to the external multipliers
//   mult_result           signed product of mul_a * mul_b (external)
//   multu_result          unsigned product of mul_a * mul_b (external)
//   hi, lo                HI/LO registers
//   busy                  multiply in flight (CPU stall)
//   done                  one-cycle pulse in the cycle after HI/LO capture
//
// state | meaning
// IDLE  | accepting requests; MTHI/MTLO complete in one edge
// WAIT  | operands held for the multiplier; counter runs down to the capture edge

module hilo_mul_unit #(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mult_result,
  input  logic [63:0] multu_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_a_d  = rs_data;
              mul_b_d  = rt_data;
              // The product type is fixed at request time; the live op is not used later.
              signed_d = (op == OP_MULT);
              cnt_d    = CNT_LOAD;
              state_d  = WAIT;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      WAIT: begin
        // Requests are ignored here. The CPU is stalled and re-presents them later.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          {hi_d, lo_d} = signed_q ? mult_result : multu_result;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == WAIT);
  assign done  = done_q;

endmodule

// File: tb/tb_hilo_mul_unit.sv
module tb_hilo_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        req2, req1;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;

  logic [31:0] mul_a2, mul_b2, hi2, lo2;
  logic        busy2, done2;
  logic [63:0] mr2, mur2;

  logic [31:0] mul_a1, mul_b1, hi1, lo1;
  logic        busy1, done1;
  logic [63:0] mr1, mur1;

  int n_checks = 0;
  int n_errors = 0;

  // External multipliers are modelled here as the environment around the unit.
  assign mr2  = $signed({{32{mul_a2[31]}}, mul_a2}) * $signed({{32{mul_b2[31]}}, mul_b2});
  assign mur2 = {32'b0, mul_a2} * {32'b0, mul_b2};
  assign mr1  = $signed({{32{mul_a1[31]}}, mul_a1}) * $signed({{32{mul_b1[31]}}, mul_b1});
  assign mur1 = {32'b0, mul_a1} * {32'b0, mul_b1};

  hilo_mul_unit #(.MUL_CYCLES(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mul_a(mul_a2), .mul_b(mul_b2),
    .mult_result(mr2), .multu_result(mur2),
    .hi(hi2), .lo(lo2), .busy(busy2), .done(done2)
  );

  hilo_mul_unit #(.MUL_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mul_a(mul_a1), .mul_b(mul_b1),
    .mult_result(mr1), .multu_result(mur1),
    .hi(hi1), .lo(lo1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r2, input logic r1, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    req2 = r2; req1 = r1; op = o; rs_data = a; rt_data = b;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick(); tick();
    check("rst_hi",    64'(hi2),    64'h0);
    check("rst_lo",    64'(lo2),    64'h0);
    check("rst_busy",  64'(busy2),  64'h0);
    check("rst_done",  64'(done2),  64'h0);
    check("rst_mul_a", 64'(mul_a2), 64'h0);
    check("rst_mul_b", 64'(mul_b2), 64'h0);
    rst_n = 1'b1;
    tick();

    // MULT -3 * 5
    drive(1'b1, 1'b0, 3'b001, 32'hFFFF_FFFD, 32'd5);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("m1_busy_c1", 64'(busy2), 64'h1);
    check("m1_done_c1", 64'(done2), 64'h0);
    check("m1_mul_a",   64'(mul_a2), 64'hFFFF_FFFD);
    check("m1_mul_b",   64'(mul_b2), 64'h5);
    check("m1_hi_hold", 64'(hi2), 64'h0);
    tick();
    check("m1_busy_c2", 64'(busy2), 64'h1);
    check("m1_done_c2", 64'(done2), 64'h0);
    tick();
    check("m1_busy_c3", 64'(busy2), 64'h0);
    check("m1_done_c3", 64'(done2), 64'h1);
    check("m1_hi",      64'(hi2), 64'hFFFF_FFFF);
    check("m1_lo",      64'(lo2), 64'hFFFF_FFF1);
    tick();
    check("m1_done_c4", 64'(done2), 64'h0);
    check("m1_mul_a_hold", 64'(mul_a2), 64'hFFFF_FFFD);

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF
    drive(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick(); tick();
    check("mu_hi", 64'(hi2), 64'hFFFF_FFFE);
    check("mu_lo", 64'(lo2), 64'h0000_0001);

    // MULT with the same operands
    drive(1'b1, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick(); tick();
    check("ms_hi", 64'(hi2), 64'h0000_0000);
    check("ms_lo", 64'(lo2), 64'h0000_0001);
    tick();

    // MTHI then MTLO on consecutive edges
    drive(1'b1, 1'b0, 3'b011, 32'h1234_5678, 32'h0);
    tick();
    check("mthi_hi",   64'(hi2), 64'h1234_5678);
    check("mthi_lo",   64'(lo2), 64'h0000_0001);
    check("mthi_busy", 64'(busy2), 64'h0);
    drive(1'b1, 1'b0, 3'b100, 32'h9ABC_DEF0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("mtlo_hi",   64'(hi2), 64'h1234_5678);
    check("mtlo_lo",   64'(lo2), 64'h9ABC_DEF0);
    check("mtlo_busy", 64'(busy2), 64'h0);
    tick();

    // MULT 7*6 with an MTLO request during WAIT
    drive(1'b1, 1'b0, 3'b001, 32'd7, 32'd6);
    tick();
    drive(1'b1, 1'b0, 3'b100, 32'hDEAD_BEEF, 32'h0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("ign_lo_mid", 64'(lo2), 64'h9ABC_DEF0);
    check("ign_busy",   64'(busy2), 64'h1);
    tick();
    check("ign_hi", 64'(hi2), 64'h0);
    check("ign_lo", 64'(lo2), 64'h0000_002A);
    check("ign_done", 64'(done2), 64'h1);
    tick();
    check("ign_busy_after", 64'(busy2), 64'h0);

    // Reset asserted during WAIT aborts the multiply
    drive(1'b1, 1'b0, 3'b010, 32'd9, 32'd9);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("ab_busy_pre", 64'(busy2), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ab_hi",    64'(hi2),    64'h0);
    check("ab_lo",    64'(lo2),    64'h0);
    check("ab_busy",  64'(busy2),  64'h0);
    check("ab_mul_a", 64'(mul_a2), 64'h0);
    check("ab_mul_b", 64'(mul_b2), 64'h0);
    #2 rst_n = 1'b1;
    tick(); tick(); tick();
    check("ab_lo_later",   64'(lo2),   64'h0);
    check("ab_done_later", 64'(done2), 64'h0);
    check("ab_busy_later", 64'(busy2), 64'h0);

    // MUL_CYCLES=1: back-to-back MULT then MULTU
    drive(1'b0, 1'b1, 3'b001, 32'd2, 32'd3);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("c1_busy_a", 64'(busy1), 64'h1);
    tick();
    check("c1_lo_a",   64'(lo1),   64'h6);
    check("c1_done_a", 64'(done1), 64'h1);
    check("c1_idle_a", 64'(busy1), 64'h0);
    drive(1'b0, 1'b1, 3'b010, 32'h8000_0000, 32'd2);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("c1_busy_b", 64'(busy1), 64'h1);
    check("c1_done_b", 64'(done1), 64'h0);
    tick();
    check("c1_hi_b",   64'(hi1),   64'h0000_0001);
    check("c1_lo_b",   64'(lo1),   64'h0000_0000);
    check("c1_done_c", 64'(done1), 64'h1);
    check("c1_idle_b", 64'(busy1), 64'h0);
    tick();
    check("c1_done_d", 64'(done1), 64'h0);
    check("c2_untouched", 64'(hi2), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
